// File: rtl/alu_pkg.sv
// alu_pkg: shared constants for the multicycle ALU.
//   - opcode map (OP_ADD .. OP_MOD), unchanged from the combinational ALU
//   - control FSM state type
//   - is_iterative(): true for opcodes served by the iterative unit
package alu_pkg;

    localparam logic [3:0] OP_ADD = 4'b0001;
    localparam logic [3:0] OP_SUB = 4'b0010;
    localparam logic [3:0] OP_AND = 4'b0011;
    localparam logic [3:0] OP_OR  = 4'b0100;
    localparam logic [3:0] OP_XOR = 4'b0101;
    localparam logic [3:0] OP_NOT = 4'b0110;
    localparam logic [3:0] OP_SHL = 4'b0111;
    localparam logic [3:0] OP_SHR = 4'b1000;
    localparam logic [3:0] OP_SLT = 4'b1001;
    localparam logic [3:0] OP_EQ  = 4'b1010;
    localparam logic [3:0] OP_MUL = 4'b1011;
    localparam logic [3:0] OP_DIV = 4'b1100;
    localparam logic [3:0] OP_MOD = 4'b1101;

    typedef enum logic [1:0] {
        IDLE,
        ITER,
        LAST
    } state_t;

    function automatic logic is_iterative(input logic [3:0] op);
        return (op == OP_MUL) || (op == OP_DIV) || (op == OP_MOD);
    endfunction

endpackage

// File: rtl/alu_multicycle_if.sv
// alu_multicycle_if: request/ready/done bus between control unit and ALU.
//   a, b, alu_op, alu_enable : request side (driven by master)
//   ready                    : ALU can accept a request this cycle
//   result, zero, div_zero   : registered results, updated with done
//   done                     : one-cycle completion pulse
interface alu_multicycle_if #(
    parameter int WIDTH = 16
);
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [3:0]       alu_op;
    logic             alu_enable;
    logic             ready;
    logic [WIDTH-1:0] result;
    logic             zero;
    logic             div_zero;
    logic             done;

    modport master (
        output a, b, alu_op, alu_enable,
        input  ready, result, zero, div_zero, done
    );

    modport slave (
        input  a, b, alu_op, alu_enable,
        output ready, result, zero, div_zero, done
    );
endinterface

// File: rtl/alu_iter_unit.sv
// alu_iter_unit: shared shift-add multiplier / restoring divider, one bit
// per cycle, WIDTH cycles per operation.
//   clk, rst    : clock, synchronous active-high reset
//   start       : load operands and begin (a, b, op_is_div sampled)
//   op_is_div   : 1 = divide/modulo, 0 = multiply
//   a, b        : operands (multiplier/multiplicand, dividend/divisor)
//   busy        : iteration in progress
//   last        : final iteration happens on the coming edge
//   prod_lo     : low WIDTH bits of the product after this iteration
//   quot, rem   : quotient / remainder after this iteration
// The outputs are the combinational next-step values so the top level can
// capture the finished result on the same edge as the last iteration.
module alu_iter_unit #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             op_is_div,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             last,
    output logic [WIDTH-1:0] prod_lo,
    output logic [WIDTH-1:0] quot,
    output logic [WIDTH-1:0] rem
);
    localparam int CW = $clog2(WIDTH);

    // acc_q: product accumulator / partial remainder
    // opnd_q: multiplicand (shifted left) / divisor
    // shreg_q: multiplier (shifted right) / dividend turning into quotient
    logic [WIDTH-1:0] acc_q;
    logic [WIDTH-1:0] opnd_q;
    logic [WIDTH-1:0] shreg_q;
    logic             div_q;
    logic [CW-1:0]    cnt_q;

    logic [WIDTH-1:0] mul_acc_next;
    logic [WIDTH:0]   trial;
    logic [WIDTH:0]   diff;
    logic             fits;
    logic [WIDTH-1:0] div_rem_next;
    logic [WIDTH-1:0] div_quot_next;

    always_comb begin
        mul_acc_next  = acc_q + (shreg_q[0] ? opnd_q : '0);
        trial         = {acc_q, shreg_q[WIDTH-1]};
        diff          = trial - {1'b0, opnd_q};
        // Compare rather than test the borrow bit: trial may use all WIDTH+1 bits.
        // A zero divisor always fits, yielding all-ones quotient and rem == a.
        fits          = (trial >= {1'b0, opnd_q});
        div_rem_next  = fits ? diff[WIDTH-1:0] : trial[WIDTH-1:0];
        div_quot_next = {shreg_q[WIDTH-2:0], fits};
    end

    assign last    = busy && (cnt_q == CW'(WIDTH - 1));
    assign prod_lo = mul_acc_next;
    assign quot    = div_quot_next;
    assign rem     = div_rem_next;

    always_ff @(posedge clk) begin
        if (rst) begin
            busy    <= 1'b0;
            div_q   <= 1'b0;
            cnt_q   <= '0;
            acc_q   <= '0;
            opnd_q  <= '0;
            shreg_q <= '0;
        end else if (start) begin
            busy    <= 1'b1;
            div_q   <= op_is_div;
            cnt_q   <= '0;
            acc_q   <= '0;
            opnd_q  <= b;
            shreg_q <= a;
        end else if (busy) begin
            cnt_q <= cnt_q + CW'(1);
            if (last) begin
                busy  <= 1'b0;
                cnt_q <= '0;
            end
            if (div_q) begin
                acc_q   <= div_rem_next;
                shreg_q <= div_quot_next;
            end else begin
                acc_q   <= mul_acc_next;
                opnd_q  <= {opnd_q[WIDTH-2:0], 1'b0};
                shreg_q <= {1'b0, shreg_q[WIDTH-1:1]};
            end
        end
    end

endmodule

// File: rtl/alu_multicycle.sv
// alu_multicycle: registered ALU with single-cycle ops and iterative
// MUL/DIV/MOD behind a request/ready/done handshake.
//   clk, rst : clock, synchronous active-high reset
//   bus      : alu_multicycle_if slave (a, b, alu_op, alu_enable in;
//              ready, result, zero, div_zero, done out)
module alu_multicycle
    import alu_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic            clk,
    input  logic            rst,
    alu_multicycle_if.slave bus
);
    state_t state_q, state_d;

    logic             ready;
    logic             accept;
    logic             start;
    logic             iter_busy;
    logic             iter_last;
    logic [WIDTH-1:0] prod_lo, quot, rem;
    logic [WIDTH-1:0] single_res;
    logic [WIDTH-1:0] iter_res;
    logic [3:0]       op_q;
    logic             b_zero_q;
    logic [WIDTH-1:0] result_q;
    logic             zero_q, div_zero_q, done_q;

    assign accept = bus.alu_enable && ready;

    alu_iter_unit #(.WIDTH(WIDTH)) u_iter (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .op_is_div(bus.alu_op != OP_MUL),
        .a        (bus.a),
        .b        (bus.b),
        .busy     (iter_busy),
        .last     (iter_last),
        .prod_lo  (prod_lo),
        .quot     (quot),
        .rem      (rem)
    );

    // FSM: state register
    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // FSM: next state
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE, LAST: state_d = (accept && is_iterative(bus.alu_op)) ? ITER : IDLE;
            ITER:       if (iter_last) state_d = LAST;
            default:    state_d = IDLE;
        endcase
    end

    // FSM: outputs
    always_comb begin
        ready = (state_q != ITER) && !iter_busy;
        start = accept && is_iterative(bus.alu_op);
    end

    always_comb begin
        single_res = '0;
        case (bus.alu_op)
            OP_ADD: single_res = bus.a + bus.b;
            OP_SUB: single_res = bus.a - bus.b;
            OP_AND: single_res = bus.a & bus.b;
            OP_OR:  single_res = bus.a | bus.b;
            OP_XOR: single_res = bus.a ^ bus.b;
            OP_NOT: single_res = ~bus.a;
            OP_SHL: single_res = {bus.a[WIDTH-2:0], 1'b0};
            OP_SHR: single_res = {1'b0, bus.a[WIDTH-1:1]};
            OP_SLT: single_res = {{(WIDTH-1){1'b0}}, bus.a < bus.b};
            OP_EQ:  single_res = {{(WIDTH-1){1'b0}}, bus.a == bus.b};
            default: single_res = '0;
        endcase
    end

    always_comb begin
        case (op_q)
            OP_MUL:  iter_res = prod_lo;
            OP_DIV:  iter_res = quot;
            default: iter_res = rem;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            result_q   <= '0;
            zero_q     <= 1'b1;
            div_zero_q <= 1'b0;
            done_q     <= 1'b0;
            op_q       <= '0;
            b_zero_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (start) begin
                op_q     <= bus.alu_op;
                b_zero_q <= (bus.b == '0);
            end
            if (accept && !is_iterative(bus.alu_op)) begin
                result_q   <= single_res;
                zero_q     <= (single_res == '0);
                div_zero_q <= 1'b0;
                done_q     <= 1'b1;
            end else if (iter_last) begin
                result_q   <= iter_res;
                zero_q     <= (iter_res == '0);
                div_zero_q <= (op_q != OP_MUL) && b_zero_q;
                done_q     <= 1'b1;
            end
        end
    end

    assign bus.ready    = ready;
    assign bus.result   = result_q;
    assign bus.zero     = zero_q;
    assign bus.div_zero = div_zero_q;
    assign bus.done     = done_q;

endmodule

// File: tb/tb_alu_multicycle.sv
module tb_alu_multicycle;
    localparam int W = 16;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    alu_multicycle_if #(.WIDTH(W)) bus ();

    alu_multicycle #(.WIDTH(W)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus.slave)
    );

    // Reference: returns {div_zero, result} from plain integer arithmetic.
    function automatic logic [W:0] model(input logic [3:0] op, input logic [W-1:0] x, input logic [W-1:0] y);
        int unsigned ux = x;
        int unsigned uy = y;
        logic [W-1:0] r = '0;
        logic dz = 1'b0;
        case (op)
            4'd1:  r = W'(ux + uy);
            4'd2:  r = W'(ux - uy);
            4'd3:  r = x & y;
            4'd4:  r = x | y;
            4'd5:  r = x ^ y;
            4'd6:  r = ~x;
            4'd7:  r = W'(ux * 2);
            4'd8:  r = W'(ux / 2);
            4'd9:  r = (ux < uy) ? W'(1) : W'(0);
            4'd10: r = (ux == uy) ? W'(1) : W'(0);
            4'd11: r = W'(ux * uy);
            4'd12: begin dz = (uy == 0); r = dz ? {W{1'b1}} : W'(ux / uy); end
            4'd13: begin dz = (uy == 0); r = dz ? x : W'(ux % uy); end
            default: r = '0;
        endcase
        return {dz, r};
    endfunction

    function automatic bit is_multi(input logic [3:0] op);
        return op == 4'd11 || op == 4'd12 || op == 4'd13;
    endfunction

    task automatic accept_op(input logic [3:0] op, input logic [W-1:0] x, input logic [W-1:0] y);
        bus.alu_op = op;
        bus.a = x;
        bus.b = y;
        bus.alu_enable = 1'b1;
        @(posedge clk);
        #1;
        bus.alu_enable = 1'b0;
    endtask

    // Steps until done (bounded), throwing ignored requests at the DUT meanwhile.
    task automatic wait_done(output int lat, output int ready_low);
        lat = 0;
        ready_low = 0;
        while (bus.done !== 1'b1 && lat < 4 * W) begin
            if (bus.ready === 1'b0) ready_low++;
            bus.alu_enable = 1'($urandom_range(0, 1));
            bus.alu_op = 4'($urandom);
            bus.a = W'($urandom);
            bus.b = W'($urandom);
            @(posedge clk);
            #1;
            lat++;
        end
        bus.alu_enable = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        bus.alu_enable = 1'b1;
        bus.alu_op = 4'd1;
        bus.a = 16'd5;
        bus.b = 16'd6;
        repeat (3) begin
            @(posedge clk);
            #1;
            checks++;
            if (bus.done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", bus.done); end
        end
        rst = 1'b0;
        bus.alu_enable = 1'b0;
        @(posedge clk);
        #1;
        checks++;
        if (bus.ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b expected 1", bus.ready); end
        checks++;
        if (bus.result !== 16'h0) begin errors++; $display("FAIL reset_result: got %h expected 0000", bus.result); end
        checks++;
        if (bus.zero !== 1'b1) begin errors++; $display("FAIL reset_zero: got %b expected 1", bus.zero); end
        checks++;
        if (bus.div_zero !== 1'b0 || bus.done !== 1'b0) begin
            errors++; $display("FAIL reset_flags: got div_zero=%b done=%b expected 0 0", bus.div_zero, bus.done);
        end
    endtask

    task automatic test_back_to_back;
        logic [3:0]   ops [4] = '{4'd1, 4'd2, 4'd9, 4'd10};
        logic [W-1:0] xa  [4] = '{16'hFFFF, 16'd5, 16'd3, 16'd4};
        logic [W-1:0] xb  [4] = '{16'h0001, 16'd7, 16'd9, 16'd4};
        logic [W-1:0] exp [4] = '{16'h0000, 16'hFFFE, 16'h0001, 16'h0001};
        for (int i = 0; i < 4; i++) begin
            accept_op(ops[i], xa[i], xb[i]);
            checks++;
            if (bus.done !== 1'b1) begin errors++; $display("FAIL b2b_done[%0d]: got %b expected 1", i, bus.done); end
            checks++;
            if (bus.result !== exp[i]) begin errors++; $display("FAIL b2b_result[%0d]: got %h expected %h", i, bus.result, exp[i]); end
            checks++;
            if (bus.zero !== (exp[i] == 0)) begin errors++; $display("FAIL b2b_zero[%0d]: got %b expected %b", i, bus.zero, exp[i] == 0); end
            checks++;
            if (bus.ready !== 1'b1) begin errors++; $display("FAIL b2b_ready[%0d]: got %b expected 1", i, bus.ready); end
        end
    endtask

    task automatic test_mul;
        int lat, rlow;
        accept_op(4'd11, 16'd300, 16'd300);
        checks++;
        if (bus.ready !== 1'b0) begin errors++; $display("FAIL mul_busy: got ready=%b expected 0", bus.ready); end
        wait_done(lat, rlow);
        checks++;
        if (lat != W) begin errors++; $display("FAIL mul_latency: got %0d expected %0d", lat, W); end
        checks++;
        if (rlow != W) begin errors++; $display("FAIL mul_ready_low: got %0d cycles expected %0d", rlow, W); end
        checks++;
        if (bus.result !== 16'h5F90) begin errors++; $display("FAIL mul_result: got %h expected 5f90", bus.result); end
        checks++;
        if (bus.zero !== 1'b0 || bus.div_zero !== 1'b0) begin
            errors++; $display("FAIL mul_flags: got zero=%b div_zero=%b expected 0 0", bus.zero, bus.div_zero);
        end
        repeat (3) begin
            @(posedge clk);
            #1;
            checks++;
            if (bus.done !== 1'b0 || bus.result !== 16'h5F90) begin
                errors++; $display("FAIL mul_hold: got done=%b result=%h expected 0 5f90", bus.done, bus.result);
            end
        end
    endtask

    task automatic test_div_mod;
        int lat, rlow;
        accept_op(4'd12, 16'd1000, 16'd7);
        wait_done(lat, rlow);
        checks++;
        if (lat != W || bus.result !== 16'd142 || bus.div_zero !== 1'b0) begin
            errors++; $display("FAIL div: got lat=%0d result=%0d dz=%b expected %0d 142 0", lat, bus.result, bus.div_zero, W);
        end
        // issued in the done cycle
        accept_op(4'd13, 16'd1000, 16'd7);
        checks++;
        if (bus.ready !== 1'b0 || bus.done !== 1'b0) begin
            errors++; $display("FAIL mod_no_bubble: got ready=%b done=%b expected 0 0", bus.ready, bus.done);
        end
        wait_done(lat, rlow);
        checks++;
        if (lat != W || bus.result !== 16'd6 || bus.div_zero !== 1'b0) begin
            errors++; $display("FAIL mod: got lat=%0d result=%0d dz=%b expected %0d 6 0", lat, bus.result, bus.div_zero, W);
        end
    endtask

    task automatic test_div_zero;
        int lat, rlow;
        accept_op(4'd12, 16'h1234, 16'h0);
        wait_done(lat, rlow);
        checks++;
        if (bus.result !== 16'hFFFF || bus.div_zero !== 1'b1) begin
            errors++; $display("FAIL div0: got result=%h dz=%b expected ffff 1", bus.result, bus.div_zero);
        end
        accept_op(4'd13, 16'h1234, 16'h0);
        wait_done(lat, rlow);
        checks++;
        if (bus.result !== 16'h1234 || bus.div_zero !== 1'b1) begin
            errors++; $display("FAIL mod0: got result=%h dz=%b expected 1234 1", bus.result, bus.div_zero);
        end
        accept_op(4'd1, 16'd1, 16'd1);
        checks++;
        if (bus.done !== 1'b1 || bus.result !== 16'd2 || bus.div_zero !== 1'b0) begin
            errors++; $display("FAIL div0_clear: got done=%b result=%h dz=%b expected 1 0002 0", bus.done, bus.result, bus.div_zero);
        end
    endtask

    task automatic test_reset_mid_mul;
        int pulses = 0;
        accept_op(4'd11, 16'd1234, 16'd77);
        repeat (7) begin
            @(posedge clk);
            #1;
        end
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        checks++;
        if (bus.done !== 1'b0 || bus.result !== 16'h0 || bus.zero !== 1'b1 || bus.ready !== 1'b1) begin
            errors++; $display("FAIL abort: got done=%b result=%h zero=%b ready=%b expected 0 0000 1 1",
                               bus.done, bus.result, bus.zero, bus.ready);
        end
        repeat (W + 4) begin
            @(posedge clk);
            #1;
            if (bus.done === 1'b1) pulses++;
        end
        checks++;
        if (pulses != 0) begin errors++; $display("FAIL abort_no_done: got %0d pulses expected 0", pulses); end
        accept_op(4'd1, 16'd3, 16'd4);
        checks++;
        if (bus.result !== 16'd7) begin errors++; $display("FAIL post_reset_add: got %h expected 0007", bus.result); end
        accept_op(4'b1111, 16'd5, 16'd6);
        checks++;
        if (bus.done !== 1'b1 || bus.result !== 16'h0 || bus.zero !== 1'b1) begin
            errors++; $display("FAIL undef_op: got done=%b result=%h zero=%b expected 1 0000 1", bus.done, bus.result, bus.zero);
        end
    endtask

    task automatic test_random;
        int lat, rlow, exp_lat;
        logic [3:0]   op;
        logic [W-1:0] x, y;
        logic [W:0]   m;
        for (int i = 0; i < 60; i++) begin
            op = 4'($urandom_range(0, 15));
            x = W'($urandom);
            y = ($urandom_range(0, 7) == 0) ? '0 : W'($urandom);
            m = model(op, x, y);
            exp_lat = is_multi(op) ? W : 0;
            accept_op(op, x, y);
            wait_done(lat, rlow);
            checks++;
            if (lat != exp_lat) begin errors++; $display("FAIL rnd_latency[%0d] op=%h: got %0d expected %0d", i, op, lat, exp_lat); end
            checks++;
            if (bus.result !== m[W-1:0]) begin
                errors++; $display("FAIL rnd_result[%0d] op=%h a=%h b=%h: got %h expected %h", i, op, x, y, bus.result, m[W-1:0]);
            end
            checks++;
            if (bus.zero !== (m[W-1:0] == 0) || bus.div_zero !== m[W]) begin
                errors++; $display("FAIL rnd_flags[%0d] op=%h: got zero=%b dz=%b expected %b %b",
                                   i, op, bus.zero, bus.div_zero, m[W-1:0] == 0, m[W]);
            end
        end
    endtask

    initial begin
        bus.alu_enable = 1'b0;
        bus.alu_op = '0;
        bus.a = '0;
        bus.b = '0;
        rst = 1'b1;
        test_reset;
        test_back_to_back;
        test_mul;
        test_div_mod;
        test_div_zero;
        test_reset_mid_mul;
        test_random;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/alu_multicycle.md
# alu_multicycle

Parametrised, registered successor to the team's 16-bit combinational ALU. It keeps the existing opcode map (codes 0001–1010) with a one-cycle registered result, and adds iterative unsigned multiply, divide and modulo that take WIDTH cycles each. A request/ready/done handshake lets the control unit issue operations back-to-back. The block sits between the register file read ports and the writeback mux.

## Interface
Parameters:
- WIDTH, 16, operand/result width in bits (≥4).

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  reset, synchronous, active-high.
- a  in  WIDTH  operand A, sampled at accept.
- b  in  WIDTH  operand B, sampled at accept.
- alu_op  in  4  opcode, sampled at accept.
- alu_enable  in  1  request; an operation is accepted on an edge where alu_enable && ready.
- ready  out  1  high when a new operation can be accepted.
- result  out  WIDTH  registered result, held until the next done.
- zero  out  1  registered flag: result == 0, updated with result.
- div_zero  out  1  registered flag: last completed DIV/MOD had b == 0.
- done  out  1  one-cycle pulse: result, zero and div_zero are updated this cycle.

## Operation
- Opcodes 0001 ADD, 0010 SUB, 0011 AND, 0100 OR, 0101 XOR, 0110 NOT a, 0111 a<<1, 1000 a>>1 (logical), 1001 unsigned a<b → 1/0, 1010 a==b → 1/0: single-cycle ops.
- 1011 MUL: low WIDTH bits of unsigned a*b, shift-add, one bit per cycle.
- 1100 DIV: unsigned quotient; 1101 MOD: unsigned remainder; restoring division, one bit per cycle.
- Division by zero: DIV returns all-ones, MOD returns a, div_zero=1. All other completions clear div_zero.
- Undefined opcodes (0000, 1110, 1111): result 0, zero 1, done pulse, latency 1.
- ADD/SUB wrap modulo 2^WIDTH. No carry output.
- FSM states: IDLE (ready=1), ITER (ready=0, iteration counter counts 0..WIDTH-1), LAST (done=1, ready=1).
  - IDLE + accept of a single-cycle op → stays IDLE. Result is registered and done is pulsed next cycle.
  - IDLE/LAST + accept of MUL/DIV/MOD → ITER.
  - ITER at count WIDTH-1 → LAST.
  - LAST with no accept → IDLE.
- Operands are latched at accept. Changes to a/b/alu_op while busy are ignored.
- alu_enable while ready=0 is ignored. The request is not queued.

## Timing
- Reset values: result 0, zero 1, div_zero 0, done 0, ready 1, state IDLE, counter 0.
- Reset asserted mid-operation aborts the operation: no done pulse, outputs take reset values at that edge.
- Single-cycle op accepted at edge k: result and done valid in the cycle after edge k (latency 1). ready stays high, so a new op is accepted every cycle.
- MUL/DIV/MOD accepted at edge k: ready low from edge k to edge k+WIDTH. Result and done valid in the cycle after edge k+WIDTH (latency WIDTH).
- In the done cycle ready is high. An op accepted at that edge is legal and starts with no bubble.
- Between done pulses, result/zero/div_zero hold their values.

## Structure
- Shared package alu_pkg holds:
  - the opcode localparams (OP_ADD … OP_MOD);
  - the FSM state enum (IDLE, ITER, LAST).
- The existing single-cycle decoder uses the same alu_pkg constants.
- One sub-module, alu_iter_unit (parametrised on WIDTH), contains:
  - the shared shift-add/restoring-divide datapath;
  - the operand registers and the bit counter.
- alu_iter_unit exposes start, op_is_div, a, b, busy, last, prod_lo, quot and rem.
- The top level holds the FSM, the single-cycle datapath, the output registers and the flags.

## Test plan
- Reset, then idle: ready=1, result=0, zero=1, done=0. Apply alu_enable with ADD during rst=1 → no done.
- Back-to-back single-cycle ops (WIDTH=16), one per cycle:
  - ADD 0xFFFF+0x0001 → 0x0000, zero=1;
  - SUB 5−7 → 0xFFFE;
  - SLT 3,9 → 1;
  - EQ 4,4 → 1.
  - Expect 4 consecutive done pulses, each one cycle after its accept.
- MUL 300×300 → result 0x5F90 (24464), done exactly 16 cycles after accept. ready low for those 16 cycles. alu_enable pulses during busy are ignored.
- DIV 1000/7 → 142; MOD 1000/7 → 6. Issue the MOD in the DIV's done cycle → accepted with no bubble. div_zero=0 after each.
- DIV 0x1234/0 → 0xFFFF, div_zero=1. Then MOD 0x1234/0 → 0x1234, div_zero=1. Then ADD 1+1 → 2, div_zero=0.
- Assert rst for one cycle mid-MUL (cycle 8) → no done pulse, result=0, zero=1, ready=1. Then opcode 1111 → result 0, done after 1 cycle.
